// File: rtl/prbs8_checker.sv
// rtl/prbs8_checker.sv - self-synchronising PRBS8 byte checker
// Seeds a predictor from the stream, locks after LOCK_CNT hits, then flywheels and counts misses.
module prbs8_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       pred, pred_nx;
  logic [3:0]       match_cnt, match_nx;
  logic [3:0]       miss_cnt, miss_nx;
  logic             locked_nx, err_nx;
  logic [ERR_W-1:0] count_nx;

  function automatic logic [7:0] step8(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      pred      <= 8'h00;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nx;
      pred      <= pred_nx;
      match_cnt <= match_nx;
      miss_cnt  <= miss_nx;
      locked    <= locked_nx;
      err_pulse <= err_nx;
      err_count <= count_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pred_nx   = pred;
    match_nx  = match_cnt;
    miss_nx   = miss_cnt;
    locked_nx = locked;
    err_nx    = 1'b0;
    count_nx  = err_count;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_data != 8'h00) begin
            pred_nx  = step8(in_data);
            match_nx = 4'd0;
            state_nx = ACQ;
          end
        end
        ACQ: begin
          if (in_data == pred) begin
            pred_nx  = step8(in_data);
            match_nx = match_cnt + 4'd1;
            if (match_nx == LOCK_CNT[3:0]) begin
              state_nx  = LOCKED;
              locked_nx = 1'b1;
              miss_nx   = 4'd0;
            end
          end else if (in_data != 8'h00) begin
            pred_nx  = step8(in_data);
            match_nx = 4'd0;
          end else begin
            state_nx = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: the predictor advances on its own so one bad byte cannot derail it.
          pred_nx = step8(pred);
          if (in_data == pred) begin
            miss_nx = 4'd0;
          end else begin
            err_nx = 1'b1;
            if (err_count != {ERR_W{1'b1}}) count_nx = err_count + 1'b1;
            miss_nx = miss_cnt + 4'd1;
            if (miss_nx == LOSS_CNT[3:0]) begin
              state_nx  = HUNT;
              locked_nx = 1'b0;
            end
          end
        end
        default: begin
          state_nx  = HUNT;
          locked_nx = 1'b0;
        end
      endcase
    end
    if (clear) count_nx = '0;
  end

  assign state_dbg = state;

endmodule
